systolic_skew_feeder: RTL

Input staging block for the triangular elimination array: accepts one matrix row per handshake as N packed words and launches them into the N column inputs of the array's top row with the diagonal skew the array requires (column j delayed j cycles behind column 0). Bubbles and array stalls propagate coherently through the skew. After a matrix's last row it drains the skew, pulses completion, and only then accepts the next matrix, so frames never overlap inside the array.

---
 rtl/systolic_skew_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Row-to-skew staging for the triangular elimination array: column j of each accepted row
// reaches the array j cycles after column 0, and frames are separated by a full skew drain.
module systolic_skew_feeder #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int MAX_ROWS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N*W-1:0]                   in_row,
  input  logic                             in_last,
  input  logic                             out_ready,
  output logic [N*W-1:0]                   x_out,
  output logic [N-1:0]                     x_valid,
  output logic                             frame_done,
  output logic [$clog2(MAX_ROWS+1)-1:0]    row_count,
  output logic                             overflow
);

  localparam int RCW = $clog2(MAX_ROWS + 1);
  localparam int DCW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [RCW-1:0] row_count_q, row_count_d, next_count;
  logic           frame_done_q, frame_done_d;
  logic           overflow_q, overflow_d;
  logic           adv, accept, hit_max, last_eff;

  // Valid/ready contract: a row transfers on a rising edge where in_valid and in_ready are both
  // high; in_ready never depends on in_valid, and out_ready low freezes every register in the block.
  assign adv        = out_ready & ~rst;
  assign in_ready   = adv & (state_q != S_DRAIN);
  assign accept     = in_valid & in_ready;
  assign next_count = (state_q == S_IDLE) ? RCW'(1) : row_count_q + RCW'(1);
  assign hit_max    = (next_count == RCW'(MAX_ROWS));
  assign last_eff   = in_last | hit_max;

  // The end of a frame is timed by the drain counter: the tagged last element leaves column N-1
  // exactly N-1 advancing cycles after it enters, so no per-column last tag needs to be stored.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    row_count_d  = row_count_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    if (adv) begin
      frame_done_d = 1'b0;
      overflow_d   = accept & hit_max & ~in_last;
      case (state_q)
        S_IDLE, S_STREAM: begin
          if (accept) begin
            row_count_d = next_count;
            if (last_eff) begin
              state_d = S_DRAIN;
              drain_d = DCW'(N - 1);
            end else begin
              state_d = S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == DCW'(1)) begin
            state_d      = S_IDLE;
            row_count_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      row_count_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      row_count_q  <= row_count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign row_count  = row_count_q;

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [j:0][W-1:0] dat_q, dat_d;
    logic [j:0]        vld_q, vld_d;

    // Bubbles enter as zero data so an invalid slot never carries a stale element.
    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (adv) begin
        dat_d[0] = accept ? in_row[j*W +: W] : '0;
        vld_d[0] = accept;
        for (int k = 1; k <= j; k++) begin
          dat_d[k] = dat_q[k-1];
          vld_d[k] = vld_q[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign x_out[j*W +: W] = dat_q[j];
    assign x_valid[j]      = vld_q[j];
  end

endmodule
